// File: rtl/serial_tx_scheduler.sv
// serial_tx_scheduler: round-robin arbiter sharing one LSB-first serial lane between M word sources
module serial_tx_scheduler #(
  parameter int N = 8,
  parameter int M = 4,
  parameter int DIV_W = 8,
  localparam int CW = $clog2(M)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [M-1:0]   req_valid,
  input  logic [M*N-1:0] req_data,
  output logic [M-1:0]   req_ready,
  input  logic [DIV_W-1:0] div,
  output logic           sdata,
  output logic           bit_strobe,
  output logic           frame,
  output logic [CW-1:0]  chan,
  output logic           busy
);
  localparam int BW = $clog2(N);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [0:0] state;
  logic [N-1:0] shreg;
  logic [BW-1:0] bcnt;
  logic [DIV_W-1:0] pcnt;
  logic [DIV_W-1:0] dlat;
  logic [CW-1:0] rr;
  logic [CW-1:0] gidx;
  logic found;
  logic bit_end;
  logic win;
  logic xfer;
  assign bit_end = pcnt == dlat;
  assign win = state == IDLE || (bit_end && bcnt == BW'(N - 1));
  assign xfer = |req_ready;
  assign sdata = state == SHIFT && shreg[0];
  assign bit_strobe = state == SHIFT && pcnt == '0;
  assign frame = state == SHIFT && bcnt == '0;
  assign busy = state == SHIFT;
  // rotating priority search starting at rr
  always_comb begin
    found = 1'b0;
    gidx = '0;
    for (int k = 0; k < M; k++) begin
      if (!found && req_valid[(int'(rr) + k) % M]) begin
        found = 1'b1;
        gidx = CW'((int'(rr) + k) % M);
      end
    end
    req_ready = (win && found && !reset) ? {{(M-1){1'b0}}, 1'b1} << gidx : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      bcnt <= '0;
      pcnt <= '0;
      dlat <= '0;
      rr <= '0;
      chan <= '0;
    end else if (xfer) begin
      state <= SHIFT;
      shreg <= req_data[gidx*N +: N];
      dlat <= div;
      chan <= gidx;
      rr <= CW'((int'(gidx) + 1) % M);
      bcnt <= '0;
      pcnt <= '0;
    end else if (state == SHIFT) begin
      pcnt <= bit_end ? '0 : pcnt + 1'b1;
      if (bit_end) begin
        shreg <= shreg >> 1;
        bcnt <= bcnt + 1'b1;
        state <= bcnt == BW'(N - 1) ? IDLE : SHIFT;
      end
    end
  end
endmodule
